csr_cnt_responder: RTL and testbench

Responder end of the core's CSR request/response handshake (valid/type/addr/data request, ready/valid/data/exception response) that the executor drives. It owns the machine and user performance counters (cycle, time, instret) plus mcountinhibit. It answers each accepted request with a one-entry registered response, and sits beside the main CSR bank on the executor's CSR request bus.

---
 rtl/river_cfg_pkg.sv | 22 ++
 rtl/csr_cnt_prescaler.sv | 32 +++
 rtl/csr_cnt_responder.sv | 140 ++++++++++++++
 tb/tb_csr_cnt_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/river_cfg_pkg.sv
// rtl/river_cfg_pkg.sv - shared core configuration: data width, CSR request bits, CSR addresses
package river_cfg_pkg;

  localparam int RISCV_ARCH = 64;

  // CSR request type bit indices
  localparam int CsrReq_ReadBit   = 0;
  localparam int CsrReq_WriteBit  = 1;
  localparam int CsrReq_TotalBits = 2;

  // CSR addresses
  localparam logic [11:0] CSR_mcountinhibit = 12'h320;
  localparam logic [11:0] CSR_mcycle        = 12'hB00;
  localparam logic [11:0] CSR_minstret      = 12'hB02;
  localparam logic [11:0] CSR_cycle         = 12'hC00;
  localparam logic [11:0] CSR_time          = 12'hC01;
  localparam logic [11:0] CSR_instret       = 12'hC02;

  // Only CY (bit 0) and IR (bit 2) of mcountinhibit exist
  localparam logic [RISCV_ARCH-1:0] MCOUNTINHIBIT_MASK = 64'h5;

endpackage

// File: rtl/csr_cnt_prescaler.sv
// rtl/csr_cnt_prescaler.sv - divides the core clock into a one-cycle tick for the time counter
// Ports:
//   i_clk   core clock
//   i_nrst  asynchronous active-low reset
//   o_tick  high for one clock out of every DIV clocks
module csr_cnt_prescaler #(
  parameter int unsigned DIV = 1
) (
  input  logic i_clk,
  input  logic i_nrst,
  output logic o_tick
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt;

  // Combinational tick so the time register advances on the same edge the
  // prescaler wraps; with DIV=1 the tick is permanently high.
  assign o_tick = (cnt == LAST);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt <= '0;
    end else if (o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/csr_cnt_responder.sv
// rtl/csr_cnt_responder.sv - CSR responder owning cycle/time/instret counters and mcountinhibit
// Ports:
//   i_clk, i_nrst                      clock, asynchronous active-low reset
//   i_req_valid/type/addr/data         CSR request from the executor
//   o_req_ready                        request accepted when high with i_req_valid
//   o_resp_valid/data/exception        registered one-entry response
//   i_resp_ready                       requester accepts the response
//   i_instr_retired                    one pulse per retired instruction
//   i_halted                           debug halt, freezes mcycle and minstret
module csr_cnt_responder
  import river_cfg_pkg::*;
#(
  parameter int unsigned CFG_TIME_DIV = 1
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic                          i_req_valid,
  input  logic [CsrReq_TotalBits-1:0]   i_req_type,
  input  logic [11:0]                   i_req_addr,
  input  logic [RISCV_ARCH-1:0]         i_req_data,
  output logic                          o_req_ready,
  output logic                          o_resp_valid,
  output logic [RISCV_ARCH-1:0]         o_resp_data,
  output logic                          o_resp_exception,
  input  logic                          i_resp_ready,
  input  logic                          i_instr_retired,
  input  logic                          i_halted
);

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  state_t                  state, state_next;
  logic [RISCV_ARCH-1:0]   mcycle, minstret, mtime;
  logic                    inh_cy, inh_ir;
  logic                    time_tick;
  logic                    accept, rd_bit, wr_bit;
  logic                    known, read_only, exc;
  logic [RISCV_ARCH-1:0]   rdata;
  logic                    we;

  csr_cnt_prescaler #(.DIV(CFG_TIME_DIV)) u_prescaler (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .o_tick (time_tick)
  );

  assign rd_bit = i_req_type[CsrReq_ReadBit];
  assign wr_bit = i_req_type[CsrReq_WriteBit];
  assign accept = i_req_valid && o_req_ready;

  // Address decode and read mux
  always_comb begin
    known     = 1'b1;
    read_only = 1'b0;
    rdata     = '0;
    case (i_req_addr)
      CSR_mcycle:        rdata = mcycle;
      CSR_minstret:      rdata = minstret;
      CSR_mcountinhibit: rdata = {{(RISCV_ARCH-3){1'b0}}, inh_ir, 1'b0, inh_cy};
      CSR_cycle:         begin rdata = mcycle;   read_only = 1'b1; end
      CSR_time:          begin rdata = mtime;    read_only = 1'b1; end
      CSR_instret:       begin rdata = minstret; read_only = 1'b1; end
      default:           known = 1'b0;
    endcase
  end

  assign exc = !known || (wr_bit && read_only) || (!rd_bit && !wr_bit);
  assign we  = accept && wr_bit && !exc;

  // FSM
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_next = ST_RESP;
      end
      ST_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Response holding register, loaded only on accept so it stays stable
  // for as long as the requester stalls.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_resp_data      <= '0;
      o_resp_exception <= 1'b0;
    end else if (accept) begin
      o_resp_data      <= exc ? '0 : rdata;
      o_resp_exception <= exc;
    end
  end

  // Counters: a CSR write overrides the increment of the same cycle.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      mcycle   <= '0;
      minstret <= '0;
      mtime    <= '0;
      inh_cy   <= 1'b0;
      inh_ir   <= 1'b0;
    end else begin
      if (we && i_req_addr == CSR_mcycle) begin
        mcycle <= i_req_data;
      end else if (!inh_cy && !i_halted) begin
        mcycle <= mcycle + 64'd1;
      end

      if (we && i_req_addr == CSR_minstret) begin
        minstret <= i_req_data;
      end else if (i_instr_retired && !inh_ir && !i_halted) begin
        minstret <= minstret + 64'd1;
      end

      if (time_tick) begin
        mtime <= mtime + 64'd1;
      end

      if (we && i_req_addr == CSR_mcountinhibit) begin
        inh_cy <= i_req_data[0];
        inh_ir <= i_req_data[2];
      end
    end
  end

endmodule

// File: tb/tb_csr_cnt_responder.sv
// tb/tb_csr_cnt_responder.sv - self-checking bench for csr_cnt_responder against a behavioural model
module tb_csr_cnt_responder;
  import river_cfg_pkg::*;

  localparam int unsigned DIV = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  req_type;
  logic [11:0] req_addr;
  logic [63:0] req_data;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_exception;
  logic        resp_ready;
  logic        instr_retired;
  logic        halted;

  always #5 clk = ~clk;

  csr_cnt_responder #(.CFG_TIME_DIV(DIV)) dut (
    .i_clk            (clk),
    .i_nrst           (rst_n),
    .i_req_valid      (req_valid),
    .i_req_type       (req_type),
    .i_req_addr       (req_addr),
    .i_req_data       (req_data),
    .o_req_ready      (req_ready),
    .o_resp_valid     (resp_valid),
    .o_resp_data      (resp_data),
    .o_resp_exception (resp_exception),
    .i_resp_ready     (resp_ready),
    .i_instr_retired  (instr_retired),
    .i_halted         (halted)
  );

  int errors = 0;
  int checks = 0;
  bit rand_side = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural register values plus a pending-response flag.
  logic [63:0] m_cy, m_ir, m_inh, m_edges, m_rdata;
  bit          m_busy, m_exc;

  task automatic model_reset();
    m_cy = 0; m_ir = 0; m_inh = 0; m_edges = 0;
    m_rdata = 0; m_exc = 0; m_busy = 0;
  endtask

  task automatic model_step();
    bit acc, rdb, wrb, known, ro, ex;
    logic [63:0] val, cy_n, ir_n, inh_n;
    acc   = req_valid && !m_busy;
    cy_n  = (!m_inh[0] && !halted) ? m_cy + 1 : m_cy;
    ir_n  = (instr_retired && !m_inh[2] && !halted) ? m_ir + 1 : m_ir;
    inh_n = m_inh;
    if (acc) begin
      rdb = req_type[0]; wrb = req_type[1];
      known = 1; ro = 0; val = 0;
      case (req_addr)
        12'hB00: val = m_cy;
        12'hB02: val = m_ir;
        12'h320: val = m_inh;
        12'hC00: begin val = m_cy; ro = 1; end
        12'hC01: begin val = m_edges / DIV; ro = 1; end
        12'hC02: begin val = m_ir; ro = 1; end
        default: known = 0;
      endcase
      ex = !known || (wrb && ro) || (!rdb && !wrb);
      m_rdata = ex ? 64'd0 : val;
      m_exc   = ex;
      if (!ex && wrb) begin
        case (req_addr)
          12'hB00: cy_n  = req_data;
          12'hB02: ir_n  = req_data;
          12'h320: inh_n = req_data & 64'h5;
          default: ;
        endcase
      end
    end
    if (acc) m_busy = 1;
    else if (m_busy && resp_ready) m_busy = 0;
    m_cy = cy_n; m_ir = ir_n; m_inh = inh_n;
    m_edges++;
  endtask

  task automatic step();
    if (rand_side) begin
      instr_retired = 1'($urandom_range(0, 1));
      halted        = ($urandom_range(0, 7) == 0);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("req_ready", {63'd0, req_ready}, {63'd0, !m_busy});
    check("resp_valid", {63'd0, resp_valid}, {63'd0, m_busy});
    if (m_busy) begin
      check("resp_data", resp_data, m_rdata);
      check("resp_exc", {63'd0, resp_exception}, {63'd0, m_exc});
    end
  endtask

  task automatic csr(input logic [1:0] t, input logic [11:0] a, input logic [63:0] d,
                     input int hold, output logic [63:0] rd, output logic ex);
    req_valid = 1; req_type = t; req_addr = a; req_data = d; resp_ready = 0;
    step();
    check("accept_latency", {63'd0, resp_valid}, 64'd1);
    rd = resp_data; ex = resp_exception;
    for (int i = 0; i < hold; i++) begin
      req_valid = rand_side ? 1'($urandom_range(0, 1)) : 1'b0;
      req_addr  = 12'(32'hB00 + 32'($urandom_range(0, 2)));
      step();
      check("hold_data", resp_data, rd);
    end
    req_valid = 0; resp_ready = 1;
    step();
    resp_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    check("rst_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_data", resp_data, 64'd0);
    check("rst_exc", {63'd0, resp_exception}, 64'd0);
    rst_n = 1;
  endtask

  logic [63:0] rd, v1, v2;
  logic        ex;
  logic [11:0] addr_tab [8];

  initial begin
    addr_tab[0] = 12'hB00; addr_tab[1] = 12'hB02; addr_tab[2] = 12'h320; addr_tab[3] = 12'hC00;
    addr_tab[4] = 12'hC01; addr_tab[5] = 12'hC02; addr_tab[6] = 12'h7FF; addr_tab[7] = 12'hB01;
    req_valid = 0; req_type = 0; req_addr = 0; req_data = 0;
    resp_ready = 0; instr_retired = 0; halted = 0;
    do_reset();

    // Free-running mcycle after reset
    repeat (11) step();
    csr(2'b01, 12'hB00, 64'd0, 0, rd, ex);
    check("t1_mcycle", rd, 64'd11);
    check("t1_exc", {63'd0, ex}, 64'd0);

    // minstret wrap
    csr(2'b10, 12'hB02, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, ex);
    instr_retired = 1; step(); instr_retired = 0;
    csr(2'b01, 12'hC02, 64'd0, 0, rd, ex);
    check("t2_instret_wrap", rd, 64'd0);

    // Read+write mcycle: old value returned, same-cycle increment dropped
    v1 = m_cy;
    csr(2'b11, 12'hB00, 64'h100, 0, rd, ex);
    check("t3_old_value", rd, v1);
    csr(2'b01, 12'hB00, 64'd0, 0, rd, ex);
    check("t3_new_value", rd, 64'h101);

    // Illegal accesses
    v1 = m_cy;
    csr(2'b10, 12'hC00, 64'h1234, 0, rd, ex);
    check("t4_ro_exc", {63'd0, ex}, 64'd1);
    check("t4_ro_data", rd, 64'd0);
    csr(2'b01, 12'hB00, 64'd0, 0, rd, ex);
    check("t4_mcycle_kept", rd, v1 + 64'd2);
    csr(2'b01, 12'h7FF, 64'd0, 0, rd, ex);
    check("t4_unknown_exc", {63'd0, ex}, 64'd1);
    csr(2'b00, 12'hB00, 64'd0, 0, rd, ex);
    check("t4_notype_exc", {63'd0, ex}, 64'd1);

    // Inhibit freezes both counters
    csr(2'b10, 12'h320, 64'h5, 0, rd, ex);
    csr(2'b01, 12'hB00, 64'd0, 0, v1, ex);
    csr(2'b01, 12'hB02, 64'd0, 0, v2, ex);
    repeat (3) begin instr_retired = 1; step(); instr_retired = 0; step(); end
    repeat (5) step();
    csr(2'b01, 12'hB00, 64'd0, 0, rd, ex);
    check("t5_mcycle_frozen", rd, v1);
    csr(2'b01, 12'hB02, 64'd0, 0, rd, ex);
    check("t5_minstret_frozen", rd, v2);
    csr(2'b01, 12'h320, 64'd0, 0, rd, ex);
    check("t5_inh_read", rd, 64'h5);
    csr(2'b10, 12'h320, 64'hFF, 0, rd, ex);
    csr(2'b01, 12'h320, 64'd0, 0, rd, ex);
    check("t5_inh_mask", rd, 64'h5);
    csr(2'b10, 12'h320, 64'h0, 0, rd, ex);

    // Held response, then reset in the middle of the hold
    req_valid = 1; req_type = 2'b01; req_addr = 12'hC01; resp_ready = 0;
    step();
    v1 = resp_data;
    repeat (4) begin
      step();
      check("t6_ready_low", {63'd0, req_ready}, 64'd0);
      check("t6_stable", resp_data, v1);
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    check("t6_rst_valid", {63'd0, resp_valid}, 64'd0);
    check("t6_rst_ready", {63'd0, req_ready}, 64'd1);
    req_valid = 0;
    @(negedge clk);
    rst_n = 1;
    step();
    check("t6_ready_after", {63'd0, req_ready}, 64'd1);

    // Randomized traffic
    rand_side = 1;
    for (int n = 0; n < 400; n++) begin
      logic [63:0] d;
      d = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                      : {32'($urandom), 32'($urandom)};
      if (addr_tab[n % 8] == 12'h320 && $urandom_range(0, 1) == 1) d = 0;
      csr(2'($urandom_range(0, 3)), addr_tab[$urandom_range(0, 7)], d,
          int'($urandom_range(0, 3)), rd, ex);
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_side = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
